usb_utmi_tx_arb: RTL and testbench
==================================

Name: usb_utmi_tx_arb

Overview:
Packet-level arbiter that shares the single UTMI transmit port of the USB PHY between two byte-stream requesters: requester 0 is the handshake generator and requester 1 is the data-packet engine. A grant is held for a whole packet. The block enforces bus turnaround, meaning no transmission starts while a receive is active or within an inter-packet gap after one. It sits between the protocol layer and the PHY's DataOut_i/TxValid_i/TxReady_o port.

Parameters:
GAP_CYCLES, 8, minimum number of idle clk cycles after TX end or after RxActive falls before a new grant; 8 equals 2 FS bit times at 48 MHz.
GAP_W, 4, width of the gap counter; must satisfy GAP_CYCLES < 2**GAP_W.

Ports:
clk  in  1  system clock, same as the PHY clock
rst  in  1  synchronous, active-high reset
usb_rst_i  in  1  USB bus reset detected by the PHY
RxActive_i  in  1  PHY receive active
TxReady_i  in  1  PHY byte-accept strobe
DataOut_o  out  8  byte to the PHY
TxValid_o  out  1  packet-in-progress to the PHY
r0_valid_i  in  1  requester 0 has a byte
r0_data_i  in  8  requester 0 byte
r0_last_i  in  1  requester 0 byte is the last byte of its packet
r0_ready_o  out  1  requester 0 byte consumed
r1_valid_i, r1_data_i, r1_last_i, r1_ready_o: same as requester 0, for requester 1
gnt_o  out  2  one-hot current grant; 00 when no grant
busy_o  out  1  state != IDLE
underrun_o  out  1  one-cycle pulse when a packet is aborted

Behaviour:
- Reset values: state IDLE, gnt_o=00, TxValid_o=0, gap_cnt=0, underrun_o=0.
- DataOut_o is a combinational mux of the granted requester's data; it is 00 when gnt_o=00.
- rN_ready_o = gnt_o[N] & (state==XMIT) & TxReady_i & rN_valid_i. This is combinational, so data is consumed in the same cycle.
- Gap counter:
  - Loaded with GAP_CYCLES in every cycle where RxActive_i=1.
  - Loaded with GAP_CYCLES in the cycle the XMIT state is left.
  - Otherwise decrements while nonzero, and saturates at 0.
- IDLE state:
  - Grant condition: any rN_valid_i, RxActive_i=0, gap_cnt=0 and usb_rst_i=0.
  - When the grant condition holds, the next cycle has gnt_o set to the winner, TxValid_o=1 and state XMIT.
  - Arbitration is fixed priority: requester 0 wins over requester 1 (see the optional feature for the alternative).
  - Grant latency is 1 cycle from the condition becoming true.
- XMIT state:
  - Normal end: when TxReady_i=1 with rN_valid_i=1 and rN_last_i=1, the byte is consumed. The next cycle has TxValid_o=0, gnt_o=00 and state GAP.
  - Underrun: when TxReady_i=1 with rN_valid_i=0, no byte is consumed. The next cycle has TxValid_o=0, gnt_o=00, underrun_o=1 and state GAP.
  - Otherwise, hold the current state and grant.
  - The grant never changes mid-packet, regardless of requests from the other requester.
- GAP state: go to IDLE in the cycle gap_cnt reaches 0 while RxActive_i=0.
- usb_rst_i=1 in any state forces IDLE next cycle, with TxValid_o=0 and gnt_o=00. If usb_rst_i arrives during XMIT, underrun_o pulses. The gap counter is loaded on that exit.
- RxActive_i rising during XMIT is ignored; the PHY gates RX with txoe.
- Simultaneous requests from both requesters with the gap expiring in the same cycle: exactly one grant is issued.

Optional Feature:
USB_TX_ARB_RR_EN
- Defined: round-robin arbitration. A last-served pointer is updated on every grant. On a tie, the requester not served last wins. The pointer resets to requester 1, so requester 0 wins the first tie.
- Undefined: fixed priority, requester 0 always wins a tie, and no pointer register exists.

Test Plan:
- Idle bus; r1 presents 3 bytes A1,A2,A3 with last on A3; TxReady_i pulses every 32 cycles -> gnt_o=10 one cycle after r1_valid_i. DataOut_o sequence is A1,A2,A3. TxValid_o falls the cycle after A3 is accepted. No new grant for 8 cycles afterwards.
- r0 and r1 request in the same cycle -> fixed priority gives gnt_o=01, then 10 after r0's packet and the 8-cycle gap. With USB_TX_ARB_RR_EN: r0 then r1, and the next tie is r0 again only if r1 was served last.
- r1 requests while RxActive_i=1 for 50 cycles -> no grant. Grant occurs exactly 9 cycles after RxActive_i falls (8 gap cycles plus 1 latency).
- r1 mid-packet drops r1_valid_i while TxReady_i=1 -> underrun_o one-cycle pulse, TxValid_o=0 next cycle, no r1_ready_o, state GAP.
- r0 requests during r1's packet -> r1 keeps the grant until its last byte; r0 is granted after the gap.
- usb_rst_i asserted mid-packet -> TxValid_o=0 and gnt_o=00 next cycle with underrun_o=1. No grant while usb_rst_i=1. rst=1 mid-packet returns all outputs to their reset values next cycle.

Source files
------------

// File: rtl/usb_utmi_tx_arb.sv
// usb_utmi_tx_arb: packet-level arbiter sharing the UTMI transmit port between two byte-stream requesters.
// Define USB_TX_ARB_RR_EN for round-robin tie breaking; otherwise requester 0 has fixed priority.
module usb_utmi_tx_arb #(
  parameter int GAP_CYCLES = 8,
  parameter int GAP_W      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       usb_rst_i,
  input  logic       RxActive_i,
  input  logic       TxReady_i,
  output logic [7:0] DataOut_o,
  output logic       TxValid_o,
  input  logic       r0_valid_i,
  input  logic [7:0] r0_data_i,
  input  logic       r0_last_i,
  output logic       r0_ready_o,
  input  logic       r1_valid_i,
  input  logic [7:0] r1_data_i,
  input  logic       r1_last_i,
  output logic       r1_ready_o,
  output logic [1:0] gnt_o,
  output logic       busy_o,
  output logic       underrun_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XMIT = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

  state_t           state_q;
  logic [1:0]       gnt_q;
  logic             txValid_q;
  logic             underrun_q;
  logic [GAP_W-1:0] gapCnt_q;
  logic [GAP_W-1:0] gapCnt_d;

  logic selValid;
  logic selLast;
  logic xmitDone;
  logic xmitUnderrun;
  logic xmitExit;
  logic grantOk;
  logic pick1;

`ifdef USB_TX_ARB_RR_EN
  // 1 means requester 1 received the most recent grant
  logic lastServed_q;
`endif

  always_comb begin
    selValid     = (gnt_q[0] & r0_valid_i) | (gnt_q[1] & r1_valid_i);
    selLast      = (gnt_q[0] & r0_last_i)  | (gnt_q[1] & r1_last_i);
    xmitDone     = (state_q == XMIT) & TxReady_i & selValid & selLast;
    xmitUnderrun = (state_q == XMIT) & TxReady_i & ~selValid;
    xmitExit     = (state_q == XMIT) & (usb_rst_i | xmitDone | xmitUnderrun);
    grantOk      = (state_q == IDLE) & (r0_valid_i | r1_valid_i) & ~RxActive_i &
                   (gapCnt_q == '0) & ~usb_rst_i;
  end

  // Receive activity and every end of transmission restart the turnaround gap
  always_comb begin
    gapCnt_d = gapCnt_q;
    if (RxActive_i || xmitExit) begin
      gapCnt_d = GAP_LOAD;
    end else if (gapCnt_q != '0) begin
      gapCnt_d = gapCnt_q - 1'b1;
    end
  end

`ifdef USB_TX_ARB_RR_EN
  assign pick1 = r1_valid_i & (~r0_valid_i | ~lastServed_q);
`else
  assign pick1 = r1_valid_i & ~r0_valid_i;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= 2'b00;
      txValid_q  <= 1'b0;
      underrun_q <= 1'b0;
      gapCnt_q   <= '0;
`ifdef USB_TX_ARB_RR_EN
      lastServed_q <= 1'b1;
`endif
    end else begin
      gapCnt_q   <= gapCnt_d;
      underrun_q <= 1'b0;
      if (usb_rst_i) begin
        state_q    <= IDLE;
        gnt_q      <= 2'b00;
        txValid_q  <= 1'b0;
        underrun_q <= (state_q == XMIT);
      end else begin
        case (state_q)
          IDLE: begin
            if (grantOk) begin
              state_q   <= XMIT;
              gnt_q     <= pick1 ? 2'b10 : 2'b01;
              txValid_q <= 1'b1;
`ifdef USB_TX_ARB_RR_EN
              lastServed_q <= pick1;
`endif
            end
          end
          XMIT: begin
            if (xmitDone || xmitUnderrun) begin
              state_q    <= GAP;
              gnt_q      <= 2'b00;
              txValid_q  <= 1'b0;
              underrun_q <= xmitUnderrun;
            end
          end
          GAP: begin
            // Leave together with the counter reaching zero so IDLE can grant at once
            if (!RxActive_i && gapCnt_d == '0) begin
              state_q <= IDLE;
            end
          end
          default: begin
            state_q   <= IDLE;
            gnt_q     <= 2'b00;
            txValid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign DataOut_o  = gnt_q[0] ? r0_data_i : (gnt_q[1] ? r1_data_i : 8'h00);
  assign r0_ready_o = gnt_q[0] & (state_q == XMIT) & TxReady_i & r0_valid_i;
  assign r1_ready_o = gnt_q[1] & (state_q == XMIT) & TxReady_i & r1_valid_i;
  assign TxValid_o  = txValid_q;
  assign gnt_o      = gnt_q;
  assign busy_o     = (state_q != IDLE);
  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_usb_utmi_tx_arb.sv
// tb_usb_utmi_tx_arb: directed scoreboard bench for usb_utmi_tx_arb.
// Expected grant/byte/underrun/drop events carry the cycle they must appear in.
module tb_usb_utmi_tx_arb;

  localparam int EV_GRANT = 0;
  localparam int EV_BYTE  = 1;
  localparam int EV_UNDER = 2;
  localparam int EV_DROP  = 3;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } evt_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       usbRst = 1'b0;
  logic       rxActive = 1'b0;
  logic       txReady = 1'b0;
  logic [7:0] dataOut;
  logic       txValid;
  logic       r0Valid = 1'b0;
  logic [7:0] r0Data = 8'h00;
  logic       r0Last = 1'b0;
  logic       r0Ready;
  logic       r1Valid = 1'b0;
  logic [7:0] r1Data = 8'h00;
  logic       r1Last = 1'b0;
  logic       r1Ready;
  logic [1:0] gnt;
  logic       busy;
  logic       underrun;

  int   cyc = 0;
  int   assertions = 0;
  int   failures = 0;
  evt_t expQ[$];
  logic [1:0] prevGnt = 2'b00;
  logic       prevTxValid = 1'b0;

  usb_utmi_tx_arb #(.GAP_CYCLES(8), .GAP_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .usb_rst_i  (usbRst),
    .RxActive_i (rxActive),
    .TxReady_i  (txReady),
    .DataOut_o  (dataOut),
    .TxValid_o  (txValid),
    .r0_valid_i (r0Valid),
    .r0_data_i  (r0Data),
    .r0_last_i  (r0Last),
    .r0_ready_o (r0Ready),
    .r1_valid_i (r1Valid),
    .r1_data_i  (r1Data),
    .r1_last_i  (r1Last),
    .r1_ready_o (r1Ready),
    .gnt_o      (gnt),
    .busy_o     (busy),
    .underrun_o (underrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kindName(input int k);
    case (k)
      EV_GRANT: return "grant";
      EV_BYTE:  return "byte";
      EV_UNDER: return "underrun";
      default:  return "txvalid_drop";
    endcase
  endfunction

  task automatic expectEvt(input int kind, input int val, input int at);
    evt_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = at;
    expQ.push_back(e);
  endtask

  task automatic scoreEvent(input int kind, input int val);
    evt_t e;
    assertions++;
    if (expQ.size() == 0) begin
      failures++;
      $display("[TB] FAIL unexpected_%s: got val=%0h at cycle %0d, required no event", kindName(kind), val, cyc);
    end else begin
      e = expQ.pop_front();
      if (e.kind != kind || e.val != val || e.cyc != cyc) begin
        failures++;
        $display("[TB] FAIL %s: got %s val=%0h cycle=%0d, required %s val=%0h cycle=%0d",
                 kindName(e.kind), kindName(kind), val, cyc, kindName(e.kind), e.val, e.cyc);
      end
    end
  endtask

  // Monitor: turns DUT output activity into events and checks them against the queue
  always @(negedge clk) begin
    if (gnt != 2'b00 && prevGnt == 2'b00) scoreEvent(EV_GRANT, int'(gnt));
    if (r0Ready || r1Ready) scoreEvent(EV_BYTE, int'({6'd0, r1Ready, r0Ready, dataOut}));
    if (underrun) scoreEvent(EV_UNDER, 0);
    if (txValid === 1'b0 && prevTxValid) scoreEvent(EV_DROP, int'(gnt));
    prevGnt     = gnt;
    prevTxValid = txValid;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tickUntil(input int target);
    if (target > cyc) tick(target - cyc);
  endtask

  task automatic applyStimulus(input int r, input logic v, input logic [7:0] d, input logic l);
    if (r == 0) begin
      r0Valid = v;
      r0Data  = d;
      r0Last  = l;
    end else begin
      r1Valid = v;
      r1Data  = d;
      r1Last  = l;
    end
  endtask

  task automatic checkOutput(input string name, input int actual, input int required);
    assertions++;
    if (actual != required) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, required %0h at cycle %0d", name, actual, required, cyc);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_gnt"}, int'(gnt), 0);
    checkOutput({tag, "_txvalid"}, int'(txValid), 0);
    checkOutput({tag, "_underrun"}, int'(underrun), 0);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_dataout"}, int'(dataOut), 0);
  endtask

  initial begin
    int c, g, f, k, win;
    logic [7:0] seq [3];
    seq[0] = 8'hA1;
    seq[1] = 8'hA2;
    seq[2] = 8'hA3;
`ifdef USB_TX_ARB_RR_EN
    win = 1;
`else
    win = 0;
`endif

    tick(2);
    checkResetOutputs("reset");
    rst = 1'b0;
    tick(2);

    $display("[TB] single r1 packet A1,A2,A3 with slow TxReady");
    c = cyc;
    applyStimulus(1, 1'b1, seq[0], 1'b0);
    expectEvt(EV_GRANT, 2, c + 1);
    tick(1);
    k = 0;
    for (int i = 0; i < 3; i++) begin
      tick(31);
      txReady = 1'b1;
      k = cyc;
      expectEvt(EV_BYTE, 'h200 | int'(seq[i]), k);
      if (i == 2) expectEvt(EV_DROP, 0, k + 1);
      tick(1);
      txReady = 1'b0;
      if (i < 2) applyStimulus(1, 1'b1, seq[i+1], (i == 1));
    end

    $display("[TB] immediate re-request waits out the gap, then underrun");
    applyStimulus(1, 1'b1, 8'hB1, 1'b0);
    g = k + 10;
    expectEvt(EV_GRANT, 2, g);
    tickUntil(g);
    txReady = 1'b1;
    expectEvt(EV_BYTE, 'h2B1, g);
    tick(1);
    applyStimulus(1, 1'b0, 8'h00, 1'b0);
    expectEvt(EV_UNDER, 0, g + 2);
    expectEvt(EV_DROP, 0, g + 2);
    tick(1);
    txReady = 1'b0;
    checkOutput("gap_busy", int'(busy), 1);
    checkOutput("gap_txvalid", int'(txValid), 0);

    $display("[TB] simultaneous requests and request during foreign packet");
    applyStimulus(0, 1'b1, 8'h5A, 1'b1);
    applyStimulus(1, 1'b1, 8'hC1, 1'b0);
    expectEvt(EV_GRANT, 1, g + 11);
    tickUntil(g + 11);
    txReady = 1'b1;
    expectEvt(EV_BYTE, 'h15A, g + 11);
    expectEvt(EV_DROP, 0, g + 12);
    tick(1);
    txReady = 1'b0;
    applyStimulus(0, 1'b0, 8'h00, 1'b0);
    expectEvt(EV_GRANT, 2, g + 21);
    tickUntil(g + 21);
    applyStimulus(0, 1'b1, 8'h77, 1'b1);
    txReady = 1'b1;
    expectEvt(EV_BYTE, 'h2C1, g + 21);
    tick(1);
    applyStimulus(1, 1'b1, 8'hC2, 1'b1);
    expectEvt(EV_BYTE, 'h2C2, g + 22);
    expectEvt(EV_DROP, 0, g + 23);
    tick(1);
    txReady = 1'b0;
    applyStimulus(1, 1'b0, 8'h00, 1'b0);
    expectEvt(EV_GRANT, 1, g + 32);
    tickUntil(g + 32);
    txReady = 1'b1;
    expectEvt(EV_BYTE, 'h177, g + 32);
    expectEvt(EV_DROP, 0, g + 33);
    tick(1);
    txReady = 1'b0;

    $display("[TB] second tie after requester 0 was served last");
    applyStimulus(0, 1'b1, 8'h11, 1'b1);
    applyStimulus(1, 1'b1, 8'h22, 1'b1);
    expectEvt(EV_GRANT, win ? 2 : 1, g + 42);
    tickUntil(g + 42);
    txReady = 1'b1;
    expectEvt(EV_BYTE, win ? 'h222 : 'h111, g + 42);
    expectEvt(EV_DROP, 0, g + 43);
    tick(1);
    txReady = 1'b0;
    applyStimulus(win, 1'b0, 8'h00, 1'b0);
    expectEvt(EV_GRANT, win ? 1 : 2, g + 52);
    tickUntil(g + 52);
    txReady = 1'b1;
    expectEvt(EV_BYTE, win ? 'h111 : 'h222, g + 52);
    expectEvt(EV_DROP, 0, g + 53);
    tick(1);
    txReady = 1'b0;
    applyStimulus(1 - win, 1'b0, 8'h00, 1'b0);

    $display("[TB] request held off by receive activity");
    rxActive = 1'b1;
    applyStimulus(1, 1'b1, 8'h33, 1'b1);
    tick(50);
    rxActive = 1'b0;
    f = cyc;
    expectEvt(EV_GRANT, 2, f + 9);
    tickUntil(f + 9);
    rxActive = 1'b1;
    txReady = 1'b1;
    expectEvt(EV_BYTE, 'h233, f + 9);
    expectEvt(EV_DROP, 0, f + 10);
    tick(1);
    rxActive = 1'b0;
    txReady = 1'b0;

    $display("[TB] USB bus reset mid-packet");
    applyStimulus(1, 1'b1, 8'h44, 1'b0);
    expectEvt(EV_GRANT, 2, f + 19);
    tickUntil(f + 20);
    usbRst = 1'b1;
    expectEvt(EV_UNDER, 0, f + 21);
    expectEvt(EV_DROP, 0, f + 21);
    tick(20);
    usbRst = 1'b0;
    expectEvt(EV_GRANT, 2, f + 41);
    tickUntil(f + 41);
    checkOutput("dataout_granted", int'(dataOut), 'h44);
    txReady = 1'b1;
    expectEvt(EV_BYTE, 'h244, f + 41);
    tick(1);
    txReady = 1'b0;

    $display("[TB] synchronous reset mid-packet");
    rst = 1'b1;
    expectEvt(EV_DROP, 0, f + 43);
    tick(1);
    checkResetOutputs("midrst");
    rst = 1'b0;
    applyStimulus(1, 1'b0, 8'h00, 1'b0);
    applyStimulus(0, 1'b1, 8'h99, 1'b1);
    expectEvt(EV_GRANT, 1, f + 44);
    tick(1);
    txReady = 1'b1;
    expectEvt(EV_BYTE, 'h199, f + 44);
    expectEvt(EV_DROP, 0, f + 45);
    tick(1);
    txReady = 1'b0;
    applyStimulus(0, 1'b0, 8'h00, 1'b0);
    tick(20);

    while (expQ.size() != 0) begin
      evt_t e;
      e = expQ.pop_front();
      assertions++;
      failures++;
      $display("[TB] FAIL missing_%s: got nothing, required val=%0h at cycle %0d", kindName(e.kind), e.val, e.cyc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
